vliw_pipe_ctrl: RTL and testbench

- Central pipeline-control block for the 2-slot VLIW pipeline.
- Drives the write-enable (regWrite/decOut1b) and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Detects load-use hazards across both slots, squashes wrong-path bundles on taken branches, and freezes the front end for multi-cycle EX operations.
- Keeps a saturating stall-cycle counter for performance visibility.

---
 rtl/vliw_pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_vliw_pipe_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vliw_pipe_ctrl.sv
// Pipeline control for the 2-slot VLIW core: PC/pipeline-register write enables,
// flushes, load-use bubbles, branch squash, multi-cycle EX freeze and a stall counter.
module vliw_pipe_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs0,
    input  logic [REG_AW-1:0] id_rt0,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rt1,
    input  logic              ex_memread0,
    input  logic              ex_memread1,
    input  logic [REG_AW-1:0] ex_rd0,
    input  logic [REG_AW-1:0] ex_rd1,
    input  logic              ex_branch_taken,
    input  logic              ex_mc_start,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [1:0]        dbg_state
);
    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MC_WAIT    = 2'd1,
        ST_MC_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_next_cnt;
    logic [CNT_W-1:0] r_stall;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_lu_hit;

    // Register 0 is hardwired to zero, so a load targeting it never hazards.
    assign w_hit0 = ex_memread0 && (ex_rd0 != '0) &&
                    ((ex_rd0 == id_rs0) || (ex_rd0 == id_rt0) ||
                     (ex_rd0 == id_rs1) || (ex_rd0 == id_rt1));
    assign w_hit1 = ex_memread1 && (ex_rd1 != '0) &&
                    ((ex_rd1 == id_rs0) || (ex_rd1 == id_rt0) ||
                     (ex_rd1 == id_rs1) || (ex_rd1 == id_rt1));
    assign w_lu_hit = w_hit0 || w_hit1;

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        memwb_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        mc_busy      = 1'b0;
        w_next_state = r_state;
        w_next_cnt   = r_cnt;

        if (reset) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_we     = 1'b0;
            w_next_state = ST_RUN;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                ST_MC_WAIT: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_we     = 1'b0;
                    exmem_flush = 1'b1;
                    mc_busy     = 1'b1;
                    if (r_cnt == '0) w_next_state = ST_MC_RELEASE;
                    else             w_next_cnt   = r_cnt - 1'b1;
                end
                default: begin
                    // In release the multi-cycle op in EX is finishing, so its start flag is stale.
                    if (r_state == ST_MC_RELEASE) w_next_state = ST_RUN;
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ex_mc_start && (r_state == ST_RUN)) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_we      = 1'b0;
                        exmem_flush  = 1'b1;
                        w_next_state = ST_MC_WAIT;
                        w_next_cnt   = CW'(MC_LAT - 2);
                    end else if (w_lu_hit) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_state <= w_next_state;
        r_cnt   <= w_next_cnt;
        if (reset)
            r_stall <= '0;
        else if (!pc_we && (r_stall != {CNT_W{1'b1}}))
            r_stall <= r_stall + 1'b1;
    end

    assign stall_cycles = r_stall;
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_vliw_pipe_ctrl.sv
// Directed bench for vliw_pipe_ctrl: expected control vectors are queued as each
// cycle is driven and checked on the following negedge.
module tb_vliw_pipe_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs0, id_rt0, id_rs1, id_rt1, ex_rd0, ex_rd1;
    logic       ex_memread0, ex_memread1, ex_branch_taken, ex_mc_start;
    logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic       ifid_flush, idex_flush, exmem_flush, mc_busy;
    logic [15:0] stall_cycles;
    logic [1:0]  dbg_state;
    logic        s_pc_we, s_ifid_we, s_idex_we, s_exmem_we, s_memwb_we;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_mc_busy;
    logic [2:0]  s_stall_cycles;
    logic [1:0]  s_dbg_state;

    always #5 clk = ~clk;

    vliw_pipe_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs0(id_rs0), .id_rt0(id_rt0), .id_rs1(id_rs1), .id_rt1(id_rt1),
        .ex_memread0(ex_memread0), .ex_memread1(ex_memread1),
        .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .mc_busy(mc_busy), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
    );

    // Narrow-counter instance for saturation; shares all stimulus.
    vliw_pipe_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rs0(id_rs0), .id_rt0(id_rt0), .id_rs1(id_rs1), .id_rt1(id_rt1),
        .ex_memread0(ex_memread0), .ex_memread1(ex_memread1),
        .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .idex_we(s_idex_we),
        .exmem_we(s_exmem_we), .memwb_we(s_memwb_we),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .mc_busy(s_mc_busy), .stall_cycles(s_stall_cycles), .dbg_state(s_dbg_state)
    );

    // Control vector: {pc, ifid, idex, exmem, memwb we; ifid, idex, exmem flush; busy}
    localparam logic [8:0] C_RST  = 9'b00000_000_0;
    localparam logic [8:0] C_NORM = 9'b11111_000_0;
    localparam logic [8:0] C_LU   = 9'b00111_010_0;
    localparam logic [8:0] C_BR   = 9'b11111_110_0;
    localparam logic [8:0] C_MCS  = 9'b00011_001_0;
    localparam logic [8:0] C_MCW  = 9'b00011_001_1;
    localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_REL = 2'd2;

    // Entry: {state[1:0], ctl[8:0], cnt16[15:0], cnt3[2:0]}
    logic [29:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    int          exp_cnt = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        id_rs0 = '0; id_rt0 = '0; id_rs1 = '0; id_rt1 = '0;
        ex_rd0 = '0; ex_rd1 = '0;
        ex_memread0 = 1'b0; ex_memread1 = 1'b0;
        ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
    endtask

    task automatic expect_out(input logic [8:0] ctl, input logic [1:0] st, input string tag);
        logic [2:0] sat;
        sat = (exp_cnt > 7) ? 3'd7 : 3'(exp_cnt);
        exp_q.push_back({st, ctl, 16'(exp_cnt), sat});
        tag_q.push_back(tag);
        if (reset)        exp_cnt = 0;
        else if (!ctl[8]) exp_cnt = exp_cnt + 1;
    endtask

    always @(negedge clk) begin
        logic [29:0] e;
        logic [10:0] obs;
        string       t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            obs = {dbg_state, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                   ifid_flush, idex_flush, exmem_flush, mc_busy};
            total++;
            assert (obs === e[29:19]) else begin
                bad++;
                $error("FAIL %s ctl: got %b want %b", t, obs, e[29:19]);
            end
            total++;
            assert (stall_cycles === e[18:3]) else begin
                bad++;
                $error("FAIL %s stall16: got %0d want %0d", t, stall_cycles, e[18:3]);
            end
            total++;
            assert (s_stall_cycles === e[2:0]) else begin
                bad++;
                $error("FAIL %s stall3: got %0d want %0d", t, s_stall_cycles, e[2:0]);
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        next_cycle(); expect_out(C_RST, S_RUN, "reset0");
        next_cycle(); expect_out(C_RST, S_RUN, "reset1");
        next_cycle(); idle(); expect_out(C_NORM, S_RUN, "release");

        // Load-use hazards
        next_cycle(); ex_memread1 = 1'b1; ex_rd1 = 5'd7; id_rt0 = 5'd7;
        expect_out(C_LU, S_RUN, "lu_slot1");
        next_cycle(); idle(); expect_out(C_NORM, S_RUN, "after_lu");
        next_cycle(); ex_memread1 = 1'b1; ex_rd1 = 5'd0; id_rt0 = 5'd0;
        expect_out(C_NORM, S_RUN, "lu_r0");
        next_cycle(); idle(); ex_memread0 = 1'b1; ex_rd0 = 5'd3; id_rs1 = 5'd3;
        expect_out(C_LU, S_RUN, "lu_slot0");
        next_cycle(); ex_memread0 = 1'b0; expect_out(C_NORM, S_RUN, "no_load");

        // Branch outranks both hazard sources
        next_cycle(); idle(); ex_branch_taken = 1'b1; ex_mc_start = 1'b1;
        ex_memread0 = 1'b1; ex_rd0 = 5'd5; id_rs0 = 5'd5;
        expect_out(C_BR, S_RUN, "br_collide");
        next_cycle(); idle(); expect_out(C_NORM, S_RUN, "after_br");

        // Multi-cycle op, start held through release
        next_cycle(); ex_mc_start = 1'b1; expect_out(C_MCS, S_RUN, "mc_start");
        next_cycle(); expect_out(C_MCW, S_WAIT, "mc_wait1");
        next_cycle(); ex_branch_taken = 1'b1; ex_memread1 = 1'b1; ex_rd1 = 5'd9; id_rs0 = 5'd9;
        expect_out(C_MCW, S_WAIT, "mc_wait2_ign");
        next_cycle(); idle(); ex_mc_start = 1'b1; expect_out(C_MCW, S_WAIT, "mc_wait3");
        next_cycle(); expect_out(C_NORM, S_REL, "mc_release");
        next_cycle(); idle(); expect_out(C_NORM, S_RUN, "after_mc");

        // Reset in the second wait cycle
        next_cycle(); ex_mc_start = 1'b1; expect_out(C_MCS, S_RUN, "rmid_start");
        next_cycle(); expect_out(C_MCW, S_WAIT, "rmid_wait1");
        next_cycle(); reset = 1'b1; expect_out(C_RST, S_WAIT, "rmid_reset");
        next_cycle(); idle(); expect_out(C_NORM, S_RUN, "rmid_after");
        next_cycle(); expect_out(C_NORM, S_RUN, "rmid_normal");

        // Three back-to-back ops: 12 frozen cycles, 3-bit counter pins at 7
        next_cycle(); ex_mc_start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            if (op != 0) next_cycle();
            expect_out(C_MCS, S_RUN, "sat_start");
            for (int w = 0; w < 3; w++) begin
                next_cycle(); expect_out(C_MCW, S_WAIT, "sat_wait");
            end
            next_cycle(); expect_out(C_NORM, S_REL, "sat_release");
        end
        next_cycle(); idle(); expect_out(C_NORM, S_RUN, "sat_final");
        next_cycle(); expect_out(C_NORM, S_RUN, "sat_hold");

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
